// File: rtl/mod6_wrap_timer_pkg.sv
// Shared types and constants for the mod-6 wrap timer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mod6_wrap_timer_pkg;

    // Width of the upstream counter output.
    localparam int CNT_W        = 4;
    // Terminal count of the upstream mod-6 counter (0..5).
    localparam int WRAP_MAX_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

endpackage : mod6_wrap_timer_pkg

// File: rtl/mod6_wrap_timer_wrap_detect.sv
// Detects the WRAP_MAX->0 wrap of the upstream counter; optional sticky range error.
// Latency: o_wrap is combinational from i_cnt_q and the registered previous value; o_err is one cycle.
// Backpressure: none; samples i_cnt_q every cycle.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_cnt_q      : upstream counter value
//   o_wrap       : high when previous sample was WRAP_MAX and current value is 0
//   o_err        : sticky flag, set when a sampled value exceeds WRAP_MAX
// Optional feature: MOD6_WRAP_TIMER_ERRCHK_EN compiles the range check; otherwise o_err is tied to 0.
module wrap_detect
    import mod6_wrap_timer_pkg::*;
#(
    parameter int WRAP_MAX = WRAP_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] i_cnt_q,
    output logic             o_wrap,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(WRAP_MAX);

    logic [CNT_W-1:0] r_prev_q;

    // Zero reset value keeps o_wrap low until a real WRAP_MAX sample has been captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_q <= '0;
        end else begin
            r_prev_q <= i_cnt_q;
        end
    end

    assign o_wrap = (r_prev_q == LP_MAX) && (i_cnt_q == '0);

`ifdef MOD6_WRAP_TIMER_ERRCHK_EN
    logic r_err;

    // Sticky until reset; observation only, never feeds the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (i_cnt_q > LP_MAX);
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule : wrap_detect

// File: rtl/mod6_wrap_timer.sv
// Programmable delay: counts upstream counter wraps after i_start and raises o_expire.
// Latency: o_busy one cycle after i_start; o_expire from the edge sampling the Nth wrap (or one cycle after i_start when delay=0).
// Backpressure: o_expire is a level held until i_ack; i_start is ignored while expired.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_cnt_q      : upstream counter value
//   i_start      : single-cycle arm request, samples i_delay
//   i_delay      : number of wraps to wait
//   i_ack        : acknowledge of o_expire
//   o_busy       : counting wraps (ARMED)
//   o_expire     : delay elapsed (EXPIRED)
//   o_wraps      : wraps counted since arming
//   o_err        : sticky illegal-count flag (only with MOD6_WRAP_TIMER_ERRCHK_EN)
module mod6_wrap_timer
    import mod6_wrap_timer_pkg::*;
#(
    parameter int WRAP_MAX = WRAP_MAX_DEF,
    parameter int DLY_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] i_cnt_q,
    input  logic             i_start,
    input  logic [DLY_W-1:0] i_delay,
    input  logic             i_ack,
    output logic             o_busy,
    output logic             o_expire,
    output logic [DLY_W-1:0] o_wraps,
    output logic             o_err
);

    state_t           r_state;
    state_t           w_state_d;
    logic [DLY_W-1:0] r_target;
    logic [DLY_W-1:0] w_target_d;
    logic [DLY_W-1:0] r_wraps;
    logic [DLY_W-1:0] w_wraps_d;
    logic [DLY_W-1:0] w_wraps_inc;
    logic             w_wrap;

    wrap_detect #(
        .WRAP_MAX (WRAP_MAX)
    ) u_wrap_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .i_cnt_q (i_cnt_q),
        .o_wrap  (w_wrap),
        .o_err   (o_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_wraps  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_target <= w_target_d;
            r_wraps  <= w_wraps_d;
        end
    end

    assign w_wraps_inc = r_wraps + DLY_W'(1);

    always_comb begin
        w_state_d  = r_state;
        w_target_d = r_target;
        w_wraps_d  = r_wraps;
        unique case (r_state)
            ST_IDLE: begin
                // A wrap coincident with the accepted start is not counted.
                if (i_start) begin
                    w_target_d = i_delay;
                    w_wraps_d  = '0;
                    w_state_d  = (i_delay == '0) ? ST_EXPIRED : ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Restart takes priority over a same-cycle wrap.
                if (i_start) begin
                    w_target_d = i_delay;
                    w_wraps_d  = '0;
                end else if (w_wrap) begin
                    w_wraps_d = w_wraps_inc;
                    if (w_wraps_inc == r_target) begin
                        w_state_d = ST_EXPIRED;
                    end
                end
            end
            ST_EXPIRED: begin
                // o_wraps keeps its final value; i_start is dropped here.
                if (i_ack) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy   = (r_state == ST_ARMED);
    assign o_expire = (r_state == ST_EXPIRED);
    assign o_wraps  = r_wraps;

endmodule : mod6_wrap_timer

// File: doc/mod6_wrap_timer.md
# mod6_wrap_timer

Downstream delay stage for the mod-6 ripple/JK counter. Watches the counter's 4-bit output, detects each 5→0 wrap, and after a programmed number of wraps raises `expire`. `expire` is held under a level/ack handshake. Together with the counter it forms the counter-with-delay datapath: the counter supplies the time base, this block turns it into a programmable delay.

## Interface
- `WRAP_MAX`, default 5: terminal count of the upstream counter; a wrap is `WRAP_MAX`→0.
- `DLY_W`, default 8: width of the delay and progress registers.
- `clk` in 1: clock, shared with the upstream counter.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cnt_q` in 4: upstream counter value, synchronous to `clk`.
- `start` in 1: single-cycle arm request; samples `delay`.
- `delay` in DLY_W: number of wraps to wait; valid when `start`=1.
- `ack` in 1: consumer acknowledge of `expire`.
- `busy` out 1: high in ARMED.
- `expire` out 1: high in EXPIRED.
- `wraps` out DLY_W: wraps counted since arming.
- `err` out 1: sticky illegal-count flag (see Configuration).

## Operation
- `prev_q` register holds the last sampled `cnt_q`.
- `wrap` = (`prev_q`==`WRAP_MAX`) && (`cnt_q`==0).
- FSM states: IDLE, ARMED, EXPIRED.
- IDLE, on `start`:
  - `delay`==0: go to EXPIRED.
  - otherwise: `target`←`delay`, `wraps`←0, go to ARMED.
- ARMED, on `start`: restart. Reload `target`, clear `wraps`, stay ARMED. Start wins over a same-cycle `wrap`, and that wrap is not counted.
- ARMED, on `wrap` with no `start`: `wraps`←`wraps`+1. If `wraps`+1 == `target`, go to EXPIRED.
- EXPIRED: `expire` held until `ack`=1, then go to IDLE. `start` is ignored here, including when it arrives with `ack`. `wraps` holds its final value.
- `ack` is ignored outside EXPIRED.
- Arithmetic: `wraps` is unsigned DLY_W bits. It cannot overflow, because it stops at `target` ≤ 2^DLY_W−1.
- A wrap in the same cycle `start` is accepted from IDLE is not counted.

## Timing
- Reset values: state=IDLE, `prev_q`=0, `target`=0, `wraps`=0, `busy`=0, `expire`=0, `err`=0. Because `prev_q`=0 at reset, no wrap is detected in the first cycle.
- All outputs are registered or decoded from registered state; there is no combinational input→output path.
- `busy` rises one cycle after `start`.
- Nth-wrap latency: `cnt_q` goes to 0 after edge k−1; `wrap` is sampled at edge k; `expire`=1 from edge k.
- `delay`=0: `expire` rises one cycle after `start`.
- `expire` falls one cycle after the cycle in which `ack`=1 is sampled.
- An asynchronous reset in any state returns all outputs to reset values immediately. The in-progress delay is lost.

## Configuration
- `MOD6_WRAP_TIMER_ERRCHK_EN` defined:
  - `err` is set when sampled `cnt_q` > `WRAP_MAX`.
  - `err` is sticky until `reset_n`.
  - It does not affect the FSM.
- `MOD6_WRAP_TIMER_ERRCHK_EN` undefined:
  - The range check is not compiled.
  - `err` is tied to 0; the port is always present.

## Structure
- Package `mod6_wrap_timer_pkg` holds:
  - the state enum (IDLE, ARMED, EXPIRED);
  - the default `WRAP_MAX`=5 constant;
  - the counter width constant 4.
- Sub-module `wrap_detect` contains the `prev_q` register, the `wrap` compare and the optional range check/`err` flop.
- The top level holds the FSM and the `target`/`wraps` registers.

## Test plan
- Reset, then `cnt_q` cycling 0..5 with no `start` → `busy`=`expire`=0 and `wraps`=0 throughout.
- `start`, `delay`=3, counter free-running → `busy` next cycle; `wraps` goes 1,2,3; `expire` rises the cycle after the third 5→0. Hold `expire` for 4 cycles, then `ack` → IDLE one cycle later.
- `start`, `delay`=0 → `expire`=1 one cycle later with `wraps`=0. `start`+`ack` together → IDLE with `busy`=0.
- ARMED with `wraps`=2, `delay`=4, then `start` with `delay`=2 coincident with a wrap → `wraps`=0. `expire` after exactly 2 further wraps.
- Assert `reset_n` low mid-ARMED (`wraps`=1) → all outputs 0 immediately. A subsequent 5→0 is not counted.
- With the macro defined, drive `cnt_q`=7 for one cycle → `err`=1 and stays 1 until reset; FSM unaffected. Without the macro, `err`=0 for the same stimulus.
